udp_chain_msg_reader: RTL and testbench
=======================================

Name: udp_chain_msg_reader

Overview:
- Receive-side counterpart of the chain message inserter, in the clk_50 (Ethernet) domain.
- Parses the byte stream of a received chain frame, captures the hop count, and walks the message list (sender, length, payload).
- Emits each message byte-serially to an inbox interface with end and abort framing.
- Non-chain frames and malformed lists are ignored or aborted cleanly.

Parameters:
- HOP_OFFSET, 43: frame byte index of the hop-count byte. Byte 0 is the first rxdv byte of the frame.
- MSG_OFFSET, 44: byte index of the first message record. Must be greater than HOP_OFFSET.
- MAX_LEN, 1500: largest legal payload length in bytes.
- GAP_TIMEOUT, 64: clk_50 cycles without rxdv that count as a dead link.

Ports:
- clk_50  in  1  Ethernet-domain clock, 50 MHz.
- rst  in  1  reset, synchronous, active-high.
- rxd  in  8  received byte, valid when rxdv=1.
- rxdv  in  1  one-cycle strobe per byte.
- rxe  in  1  one-cycle end-of-frame pulse. Never coincident with rxdv.
- is_chain  in  1  frame classified as a chain frame. Stable from before HOP_OFFSET until rxe.
- inbox_d  out  8  message payload byte.
- inbox_dv  out  1  inbox_d valid.
- inbox_e  out  1  last payload byte. Asserted together with inbox_dv.
- inbox_abort  out  1  one-cycle pulse: current message was truncated and must be discarded.
- inbox_sender  out  16  sender of the current message. Stable from first inbox_dv to inbox_e/abort.
- inbox_len  out  16  length of the current message. Stable over the same window.
- hop_count  out  8  hop byte of the most recent chain frame.
- hop_count_valid  out  1  one-cycle pulse when hop_count updates.
- msg_cnt  out  16  messages fully delivered. Wraps.
- err_cnt  out  8  aborted or illegal messages. Saturates at 0xFF.

Behaviour:
- Reset values:
  - All outputs 0.
  - State RESYNC; byte counter 0; gap counter 0.
- Timing:
  - All outputs registered; latency is 1 cycle from the rxdv byte to the corresponding inbox_dv/hop_count_valid.
  - 16-bit byte counter increments on rxdv and clears on entry to IDLE.
  - Gap counter clears on rxdv and otherwise increments, saturating.
- States and transitions:
  - RESYNC: go to IDLE on rxe, or when the gap counter reaches GAP_TIMEOUT. rxdv is ignored, so reset mid-frame never misparses the frame tail.
  - IDLE: rxdv goes to HDR (that byte is index 0).
  - HDR: on the rxdv with index HOP_OFFSET:
    - if is_chain=0, go to DRAIN;
    - otherwise latch hop_count=rxd, pulse hop_count_valid, go to GAP.
  - GAP: skip bytes until index MSG_OFFSET-1 is consumed, then go to SND_LO. If MSG_OFFSET=HOP_OFFSET+1, go directly to SND_LO.
  - SND_LO: latch sender[7:0] on rxdv, go to SND_HI.
  - SND_HI: latch sender[15:8] on rxdv.
    - sender==0x0000 is end-of-list: go to DRAIN.
    - Otherwise go to LEN_LO.
  - LEN_LO: latch len[7:0] on rxdv, go to LEN_HI.
  - LEN_HI: latch len[15:8] on rxdv.
    - len==0 or len>MAX_LEN: err_cnt++, go to DRAIN, no inbox activity.
    - Otherwise load remaining=len, drive inbox_sender/inbox_len, go to PAYLOAD.
  - PAYLOAD: each rxdv produces inbox_dv with inbox_d=rxd and remaining decrements.
    - On the byte where remaining==1, also assert inbox_e, msg_cnt++, go to SND_LO (next record).
  - DRAIN: wait for rxe, then go to IDLE.
- Frame end and timeouts:
  - rxe in any state other than IDLE/RESYNC/DRAIN goes to IDLE.
  - If that state is PAYLOAD, also pulse inbox_abort the next cycle, err_cnt++, and do not increment msg_cnt.
  - rxe in LEN_LO/LEN_HI/SND_* is not an error.
  - Gap counter reaching GAP_TIMEOUT in any state other than IDLE/RESYNC: handled as rxe (same abort rule), then go to IDLE.
- Simultaneous and mid-operation events:
  - rst has priority over everything: any open message ends with no inbox_e and no abort pulse, and the state goes to RESYNC.
  - FCS bytes reach this block as ordinary bytes. An unterminated list can consume them; rxe bounds this.
  - inbox_e and inbox_abort are never asserted in the same cycle.
  - At most one inbox_e or inbox_abort per message.

Test Plan:
- Chain frame, hop byte 0x05, one record (sender 0x0007, len 3, payload AA BB CC), then sender 0x0000 -> hop_count=0x05 with one valid pulse; inbox_dv x3 of AA,BB,CC; inbox_e on CC; inbox_sender=0x0007, inbox_len=3; msg_cnt=1, err_cnt=0.
- Two back-to-back records, len 1 (0x11) and len 2 (0x22 0x33), with no terminator before rxe -> two inbox_e pulses; msg_cnt=2; no abort.
- Non-chain frame (is_chain=0) of 100 bytes -> no hop_count_valid, no inbox activity, counters unchanged.
- Record with len 5 where rxe arrives after 2 payload bytes -> 2 inbox_dv; inbox_abort one cycle after rxe; err_cnt=1, msg_cnt unchanged.
- Record with len 0x0600 (above MAX_LEN), followed by a valid record in the same frame -> err_cnt=1; the second record is not delivered (DRAIN); next frame parses normally.
- rst asserted mid-payload while the frame continues, then GAP_TIMEOUT idle, then a new valid frame -> no output from the old frame tail; the new frame parses correctly.

Source files
------------

// File: rtl/udp_chain_msg_reader.sv
// udp_chain_msg_reader
// Parses received chain frames, captures the hop count, then walks the
// message list (sender, length, payload) and emits each message byte-serially
// on an inbox interface with end and abort framing. Non-chain frames and
// malformed lists are drained until end of frame.
module udp_chain_msg_reader #(
  parameter int HOP_OFFSET  = 43,
  parameter int MSG_OFFSET  = 44,
  parameter int MAX_LEN     = 1500,
  parameter int GAP_TIMEOUT = 64
) (
  input  logic        clk_50,
  input  logic        rst,
  input  logic [7:0]  rxd,
  input  logic        rxdv,
  input  logic        rxe,
  input  logic        is_chain,
  output logic [7:0]  inbox_d,
  output logic        inbox_dv,
  output logic        inbox_e,
  output logic        inbox_abort,
  output logic [15:0] inbox_sender,
  output logic [15:0] inbox_len,
  output logic [7:0]  hop_count,
  output logic        hop_count_valid,
  output logic [15:0] msg_cnt,
  output logic [7:0]  err_cnt
);

  localparam int GAP_W = $clog2(GAP_TIMEOUT + 1);

  typedef enum logic [3:0] {
    RESYNC, IDLE, HDR, GAP, SND_LO, SND_HI, LEN_LO, LEN_HI, PAYLOAD, DRAIN
  } state_t;

  state_t             state_reg;
  logic [15:0]        byte_cnt_reg;
  logic [GAP_W-1:0]   gap_cnt_reg;
  logic [15:0]        remaining_reg;
  logic [15:0]        sender_reg;
  logic [7:0]         len_lo_reg;

  logic               timeout;
  logic               frame_end;
  logic [15:0]        len_word;
  logic [15:0]        sender_word;

  // A silent link for GAP_TIMEOUT cycles is treated exactly like an rxe.
  assign timeout     = (gap_cnt_reg == GAP_W'(GAP_TIMEOUT));
  assign frame_end   = rxe || timeout;
  assign len_word    = {rxd, len_lo_reg};
  assign sender_word = {rxd, sender_reg[7:0]};

  // Frame parser: byte/gap counters, list walk and all registered outputs.
  always_ff @(posedge clk_50) begin
    if (rst) begin
      state_reg       <= RESYNC;
      byte_cnt_reg    <= '0;
      gap_cnt_reg     <= '0;
      remaining_reg   <= '0;
      sender_reg      <= '0;
      len_lo_reg      <= '0;
      inbox_d         <= '0;
      inbox_dv        <= 1'b0;
      inbox_e         <= 1'b0;
      inbox_abort     <= 1'b0;
      inbox_sender    <= '0;
      inbox_len       <= '0;
      hop_count       <= '0;
      hop_count_valid <= 1'b0;
      msg_cnt         <= '0;
      err_cnt         <= '0;
    end else begin
      inbox_dv        <= 1'b0;
      inbox_e         <= 1'b0;
      inbox_abort     <= 1'b0;
      hop_count_valid <= 1'b0;

      if (rxdv) begin
        gap_cnt_reg <= '0;
      end else if (!timeout) begin
        gap_cnt_reg <= gap_cnt_reg + 1'b1;
      end

      // Index of the current rxdv byte is byte_cnt_reg before this increment;
      // branches that return to IDLE override it with a clear.
      if (rxdv) begin
        byte_cnt_reg <= byte_cnt_reg + 16'd1;
      end

      case (state_reg)
        RESYNC: begin
          // rxdv ignored here so a frame tail after reset is never parsed.
          if (frame_end) begin
            state_reg    <= IDLE;
            byte_cnt_reg <= '0;
          end
        end
        IDLE: begin
          if (rxdv) begin
            state_reg <= HDR;
          end
        end
        DRAIN: begin
          if (frame_end) begin
            state_reg    <= IDLE;
            byte_cnt_reg <= '0;
          end
        end
        default: begin
          if (frame_end) begin
            state_reg    <= IDLE;
            byte_cnt_reg <= '0;
            if (state_reg == PAYLOAD) begin
              inbox_abort <= 1'b1;
              err_cnt     <= (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
            end
          end else if (rxdv) begin
            case (state_reg)
              HDR: begin
                if (byte_cnt_reg == 16'(HOP_OFFSET)) begin
                  if (!is_chain) begin
                    state_reg <= DRAIN;
                  end else begin
                    hop_count       <= rxd;
                    hop_count_valid <= 1'b1;
                    state_reg       <= (MSG_OFFSET == HOP_OFFSET + 1) ? SND_LO : GAP;
                  end
                end
              end
              GAP: begin
                if (byte_cnt_reg == 16'(MSG_OFFSET - 1)) begin
                  state_reg <= SND_LO;
                end
              end
              SND_LO: begin
                sender_reg[7:0] <= rxd;
                state_reg       <= SND_HI;
              end
              SND_HI: begin
                sender_reg[15:8] <= rxd;
                state_reg        <= (sender_word == 16'h0000) ? DRAIN : LEN_LO;
              end
              LEN_LO: begin
                len_lo_reg <= rxd;
                state_reg  <= LEN_HI;
              end
              LEN_HI: begin
                if (len_word == 16'd0 || len_word > 16'(MAX_LEN)) begin
                  err_cnt   <= (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
                  state_reg <= DRAIN;
                end else begin
                  remaining_reg <= len_word;
                  inbox_sender  <= sender_reg;
                  inbox_len     <= len_word;
                  state_reg     <= PAYLOAD;
                end
              end
              PAYLOAD: begin
                inbox_d       <= rxd;
                inbox_dv      <= 1'b1;
                remaining_reg <= remaining_reg - 16'd1;
                if (remaining_reg == 16'd1) begin
                  inbox_e   <= 1'b1;
                  msg_cnt   <= msg_cnt + 16'd1;
                  state_reg <= SND_LO;
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_udp_chain_msg_reader.sv
// Scoreboard bench for udp_chain_msg_reader: expected inbox events and hop
// bytes are queued as each frame is built and popped as the DUT emits them.
module tb_udp_chain_msg_reader;

  localparam int HOP = 43;

  logic        clk_50 = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rxd = '0;
  logic        rxdv = 1'b0;
  logic        rxe = 1'b0;
  logic        is_chain = 1'b1;
  logic [7:0]  inbox_d;
  logic        inbox_dv;
  logic        inbox_e;
  logic        inbox_abort;
  logic [15:0] inbox_sender;
  logic [15:0] inbox_len;
  logic [7:0]  hop_count;
  logic        hop_count_valid;
  logic [15:0] msg_cnt;
  logic [7:0]  err_cnt;

  udp_chain_msg_reader dut (
    .clk_50(clk_50), .rst(rst), .rxd(rxd), .rxdv(rxdv), .rxe(rxe),
    .is_chain(is_chain), .inbox_d(inbox_d), .inbox_dv(inbox_dv),
    .inbox_e(inbox_e), .inbox_abort(inbox_abort), .inbox_sender(inbox_sender),
    .inbox_len(inbox_len), .hop_count(hop_count), .hop_count_valid(hop_count_valid),
    .msg_cnt(msg_cnt), .err_cnt(err_cnt)
  );

  always #10 clk_50 = ~clk_50;

  typedef struct packed {
    logic        abort;
    logic        e;
    logic [7:0]  d;
    logic [15:0] sender;
    logic [15:0] len;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] hop_q[$];
  logic [7:0] body[$];
  ev_t        mon_ev;
  logic [7:0] mon_hop;
  logic [15:0] cur_s;
  logic [15:0] cur_l;
  bit         mon_en = 1'b0;
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: compare every inbox event and hop pulse against the queues.
  always @(negedge clk_50) begin
    if (mon_en && !rst) begin
      if (inbox_dv || inbox_abort) begin
        if (exp_q.size() == 0) begin
          check("unexpected_inbox", 32'({inbox_dv, inbox_abort}), 32'd0);
        end else begin
          mon_ev = exp_q.pop_front();
          check("abort", 32'(inbox_abort), 32'(mon_ev.abort));
          check("e_with_abort", 32'(inbox_e & inbox_abort), 32'd0);
          if (!mon_ev.abort) begin
            $display("inbox byte 0x%02h e=%0d sender=0x%04h len=%0d",
                     inbox_d, inbox_e, inbox_sender, inbox_len);
            check("inbox_d", 32'(inbox_d), 32'(mon_ev.d));
            check("inbox_e", 32'(inbox_e), 32'(mon_ev.e));
            check("inbox_sender", 32'(inbox_sender), 32'(mon_ev.sender));
            check("inbox_len", 32'(inbox_len), 32'(mon_ev.len));
          end else begin
            $display("inbox abort");
          end
        end
      end
      if (inbox_e && !inbox_dv) check("e_without_dv", 32'(inbox_e), 32'd0);
      if (hop_count_valid) begin
        if (hop_q.size() == 0) begin
          check("unexpected_hop", 32'(hop_count_valid), 32'd0);
        end else begin
          mon_hop = hop_q.pop_front();
          $display("hop pulse 0x%02h", hop_count);
          check("hop_count", 32'(hop_count), 32'(mon_hop));
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rxd  = b;
    rxdv = 1'b1;
    @(posedge clk_50); #1;
    rxdv = 1'b0;
    @(posedge clk_50); #1;
  endtask

  task automatic pulse_rxe();
    rxe = 1'b1;
    @(posedge clk_50); #1;
    rxe = 1'b0;
    @(posedge clk_50); #1;
  endtask

  task automatic send_hdr(input logic [7:0] hop);
    for (int i = 0; i < HOP; i++) send_byte(8'(i + 16));
    send_byte(hop);
  endtask

  task automatic send_body();
    foreach (body[i]) send_byte(body[i]);
    body.delete();
  endtask

  task automatic b1(input logic [7:0] x);
    body.push_back(x);
  endtask

  task automatic rec(input logic [15:0] s, input logic [15:0] l);
    cur_s = s;
    cur_l = l;
    b1(s[7:0]); b1(s[15:8]); b1(l[7:0]); b1(l[15:8]);
  endtask

  task automatic pay(input logic [7:0] x, input logic last);
    ev_t v;
    b1(x);
    v.abort = 1'b0; v.e = last; v.d = x; v.sender = cur_s; v.len = cur_l;
    exp_q.push_back(v);
  endtask

  task automatic exp_abort();
    ev_t v;
    v = '0;
    v.abort = 1'b1;
    exp_q.push_back(v);
  endtask

  task automatic settle(input string tag, input int msgs, input int errs, input logic [7:0] hop);
    repeat (4) @(posedge clk_50);
    #1;
    $display("%s: msg_cnt=%0d err_cnt=%0d hop=0x%02h", tag, msg_cnt, err_cnt, hop_count);
    check({tag, "_msg_cnt"}, 32'(msg_cnt), 32'(msgs));
    check({tag, "_err_cnt"}, 32'(err_cnt), 32'(errs));
    check({tag, "_hop"}, 32'(hop_count), 32'(hop));
    check({tag, "_pending_inbox"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_pending_hop"}, 32'(hop_q.size()), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_hop"}, 32'(hop_count), 32'd0);
    check({tag, "_hop_v"}, 32'(hop_count_valid), 32'd0);
    check({tag, "_d"}, 32'(inbox_d), 32'd0);
    check({tag, "_dv"}, 32'(inbox_dv), 32'd0);
    check({tag, "_e"}, 32'(inbox_e), 32'd0);
    check({tag, "_abort"}, 32'(inbox_abort), 32'd0);
    check({tag, "_sender"}, 32'(inbox_sender), 32'd0);
    check({tag, "_len"}, 32'(inbox_len), 32'd0);
    check({tag, "_msg"}, 32'(msg_cnt), 32'd0);
    check({tag, "_err"}, 32'(err_cnt), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk_50);
    #1;
    check_zero("reset");
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (70) @(posedge clk_50);
    #1;

    // single record then terminator and FCS
    hop_q.push_back(8'h05);
    rec(16'h0007, 16'd3);
    pay(8'hAA, 1'b0); pay(8'hBB, 1'b0); pay(8'hCC, 1'b1);
    b1(8'h00); b1(8'h00);
    b1(8'hDE); b1(8'hAD); b1(8'hBE); b1(8'hEF);
    send_hdr(8'h05); send_body(); pulse_rxe();
    settle("one_rec", 1, 0, 8'h05);

    // two back-to-back records, no terminator
    hop_q.push_back(8'h06);
    rec(16'h0102, 16'd1); pay(8'h11, 1'b1);
    rec(16'h0203, 16'd2); pay(8'h22, 1'b0); pay(8'h33, 1'b1);
    send_hdr(8'h06); send_body(); pulse_rxe();
    settle("two_rec", 3, 0, 8'h06);

    // non-chain frame of 100 bytes
    is_chain = 1'b0;
    for (int i = 0; i < 56; i++) b1(8'(i));
    send_hdr(8'h99); send_body(); pulse_rxe();
    is_chain = 1'b1;
    settle("non_chain", 3, 0, 8'h06);

    // truncated payload: rxe after 2 of 5 bytes
    hop_q.push_back(8'h07);
    rec(16'h0009, 16'd5); pay(8'h01, 1'b0); pay(8'h02, 1'b0);
    exp_abort();
    send_hdr(8'h07); send_body(); pulse_rxe();
    settle("trunc", 3, 1, 8'h07);

    // oversize length drains the rest of the frame
    hop_q.push_back(8'h08);
    rec(16'h000A, 16'h0600);
    rec(16'h000B, 16'd1); b1(8'h44);
    send_hdr(8'h08); send_body(); pulse_rxe();
    settle("oversize", 3, 2, 8'h08);

    // following frame parses normally
    hop_q.push_back(8'h09);
    rec(16'h000C, 16'd2); pay(8'h55, 1'b0); pay(8'h66, 1'b1);
    b1(8'h00); b1(8'h00);
    send_hdr(8'h09); send_body(); pulse_rxe();
    settle("after_drain", 4, 2, 8'h09);

    // gap timeout mid-payload aborts like rxe
    hop_q.push_back(8'h0C);
    rec(16'h000D, 16'd3); pay(8'h77, 1'b0);
    exp_abort();
    send_hdr(8'h0C); send_body();
    repeat (70) @(posedge clk_50);
    #1;
    settle("timeout", 4, 3, 8'h0C);

    // reset mid-payload, frame tail continues, link goes quiet, new frame
    hop_q.push_back(8'h0D);
    rec(16'h000E, 16'd6); pay(8'h01, 1'b0); pay(8'h02, 1'b0);
    send_hdr(8'h0D); send_body();
    rst = 1'b1;
    @(posedge clk_50); #1;
    check_zero("midrst");
    rst = 1'b0;
    b1(8'h03); b1(8'h04); b1(8'h05); b1(8'h06);
    rec(16'h000F, 16'd1); b1(8'h88); b1(8'h00); b1(8'h00);
    send_body();
    repeat (70) @(posedge clk_50);
    #1;
    hop_q.push_back(8'h0E);
    rec(16'h0010, 16'd1); pay(8'h99, 1'b1);
    b1(8'h00); b1(8'h00);
    send_hdr(8'h0E); send_body(); pulse_rxe();
    settle("post_rst", 1, 0, 8'h0E);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
